// File: rtl/mixer_pkg.sv
// Shared constants and helpers for the NCO complex mixer (nco_mixer_ch) and its cosine table.
package mixer_pkg;

   localparam int DEF_DATA_W     = 8;
   localparam int DEF_COEF_W     = 8;
   localparam int DEF_LUT_ADDR_W = 10;
   localparam int DEF_PHASE_W    = 32;
   localparam int DEF_FRAC_W     = 22;
   localparam int LATENCY        = 4;

   // Half an output LSB in product units, so the arithmetic shift rounds half up.
   function automatic int round_ofs(input int coef_w);
      return 1 << (coef_w - 2);
   endfunction

   localparam int ROUND_OFS = 1 << (DEF_COEF_W - 2);

   function automatic logic signed [31:0] saturate(input logic signed [31:0] v, input int w);
      logic signed [31:0] hi, lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -hi - 32'sd1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   // Quantised cosine sample k of a 2^addr_w-entry turn, rounded half away from zero.
   function automatic int cos_q(input int k, input int addr_w, input int coef_w);
      real amp, x;
      amp = real'((1 << (coef_w - 1)) - 1);
      x   = amp * $cos(2.0 * 3.141592653589793 * real'(k) / real'(1 << addr_w));
      return (x < 0.0) ? -$rtoi(0.5 - x) : $rtoi(x + 0.5);
   endfunction

endpackage

// File: rtl/nco_cos_rom.sv
// Full-turn cosine table with two registered read ports; one port serves cos, the other sin
// (addressed a quarter turn back). Contents are fixed at elaboration.
module nco_cos_rom
   import mixer_pkg::*;
#(
   parameter int COEF_W = DEF_COEF_W,
   parameter int ADDR_W = DEF_LUT_ADDR_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADDR_W-1:0]        addr_a_i,
   input  logic [ADDR_W-1:0]        addr_b_i,
   output logic signed [COEF_W-1:0] data_a_o,
   output logic signed [COEF_W-1:0] data_b_o
);

   localparam int DEPTH = 1 << ADDR_W;

   logic signed [COEF_W-1:0] tbl [DEPTH];
   logic signed [COEF_W-1:0] rd_a_q, rd_b_q;

   for (genvar k = 0; k < DEPTH; k++) begin : g_tbl
      assign tbl[k] = COEF_W'(cos_q(k, ADDR_W, COEF_W));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_a_q <= '0;
         rd_b_q <= '0;
      end else begin
         rd_a_q <= tbl[addr_a_i];
         rd_b_q <= tbl[addr_b_i];
      end
   end

   assign data_a_o = rd_a_q;
   assign data_b_o = rd_b_q;

endmodule

// File: rtl/nco_mixer_ch.sv
// Complex mixer: rotates each valid sample by the RAM-LUT NCO phase, 4-cycle fixed latency.
// Define MIXER_SAT_CNT_EN to add the saturating output-saturation counter port sat_cnt_o.
module nco_mixer_ch
   import mixer_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int COEF_W     = DEF_COEF_W,
   parameter int LUT_ADDR_W = DEF_LUT_ADDR_W,
   parameter int PHASE_W    = DEF_PHASE_W,
   parameter int FRAC_W     = DEF_FRAC_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DATA_W-1:0]  real_i,
   input  logic [DATA_W-1:0]  imag_i,
   input  logic               valid_i,
   input  logic [PHASE_W-1:0] delta_index_i,
   input  logic               mode_up_i,
   input  logic               phase_clr_i,
   output logic [DATA_W-1:0]  real_o,
   output logic [DATA_W-1:0]  imag_o,
   output logic               valid_o
`ifdef MIXER_SAT_CNT_EN
   ,
   output logic [15:0]        sat_cnt_o
`endif
);

   localparam int PROD_W = DATA_W + COEF_W;
   localparam int SUM_W  = PROD_W + 1;
   localparam int SHIFT  = COEF_W - 1;
   localparam int RND    = round_ofs(COEF_W);
   localparam logic [LUT_ADDR_W-1:0] QUARTER = LUT_ADDR_W'(1 << (LUT_ADDR_W - 2));

   // The LUT address must lie within the integer part of the phase word.
   if (PHASE_W < FRAC_W + LUT_ADDR_W) begin : g_cfg_chk
      $error("nco_mixer_ch: PHASE_W too small for FRAC_W + LUT_ADDR_W");
   end

   // ---------------- phase accumulator ----------------
   logic [PHASE_W-1:0]    acc_q, acc_d;
   logic [LUT_ADDR_W-1:0] cos_addr, sin_addr;

   always_comb begin
      cos_addr = acc_q[PHASE_W-1 -: LUT_ADDR_W];
      acc_d    = acc_q;
      if (phase_clr_i) begin
         cos_addr = '0;
         acc_d    = valid_i ? delta_index_i : '0;
      end else if (valid_i) begin
         acc_d = acc_q + delta_index_i;
      end
   end

   assign sin_addr = cos_addr - QUARTER;

   // ---------------- S1: LUT read, sample/mode capture ----------------
   logic signed [COEF_W-1:0] cos1, sin1;
   logic signed [DATA_W-1:0] a1_q, b1_q;
   logic                     up1_q;

   nco_cos_rom #(.COEF_W(COEF_W), .ADDR_W(LUT_ADDR_W)) u_rom (
      .clk      (clk),
      .rst      (rst),
      .addr_a_i (cos_addr),
      .addr_b_i (sin_addr),
      .data_a_o (cos1),
      .data_b_o (sin1)
   );

   // ---------------- S2..S4 datapath ----------------
   logic signed [PROD_W-1:0] ac2_q, bs2_q, bc2_q, as2_q;
   logic                     up2_q;
   logic signed [SUM_W-1:0]  re3_q, im3_q, re3_d, im3_d;
   logic signed [31:0]       re_sh, im_sh;
   logic [DATA_W-1:0]        real_q, imag_q, real_d, imag_d;
   logic [LATENCY:1]         vld_pipe_q;

   always_comb begin
      if (up2_q) begin
         re3_d = SUM_W'(ac2_q) - SUM_W'(bs2_q);
         im3_d = SUM_W'(as2_q) + SUM_W'(bc2_q);
      end else begin
         re3_d = SUM_W'(ac2_q) + SUM_W'(bs2_q);
         im3_d = SUM_W'(bc2_q) - SUM_W'(as2_q);
      end
   end

   // Outputs hold between valid results.
   always_comb begin
      re_sh  = (32'(re3_q) + 32'(RND)) >>> SHIFT;
      im_sh  = (32'(im3_q) + 32'(RND)) >>> SHIFT;
      real_d = real_q;
      imag_d = imag_q;
      if (vld_pipe_q[LATENCY-1]) begin
         real_d = DATA_W'(saturate(re_sh, DATA_W));
         imag_d = DATA_W'(saturate(im_sh, DATA_W));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q      <= '0;
         a1_q       <= '0;
         b1_q       <= '0;
         up1_q      <= 1'b0;
         ac2_q      <= '0;
         bs2_q      <= '0;
         bc2_q      <= '0;
         as2_q      <= '0;
         up2_q      <= 1'b0;
         re3_q      <= '0;
         im3_q      <= '0;
         real_q     <= '0;
         imag_q     <= '0;
         vld_pipe_q <= '0;
      end else begin
         acc_q      <= acc_d;
         a1_q       <= real_i;
         b1_q       <= imag_i;
         up1_q      <= mode_up_i;
         ac2_q      <= PROD_W'(a1_q) * PROD_W'(cos1);
         bs2_q      <= PROD_W'(b1_q) * PROD_W'(sin1);
         bc2_q      <= PROD_W'(b1_q) * PROD_W'(cos1);
         as2_q      <= PROD_W'(a1_q) * PROD_W'(sin1);
         up2_q      <= up1_q;
         re3_q      <= re3_d;
         im3_q      <= im3_d;
         real_q     <= real_d;
         imag_q     <= imag_d;
         vld_pipe_q <= {vld_pipe_q[LATENCY-1:1], valid_i};
      end
   end

   assign real_o  = real_q;
   assign imag_o  = imag_q;
   assign valid_o = vld_pipe_q[LATENCY];

`ifdef MIXER_SAT_CNT_EN
   logic        sat_any;
   logic [15:0] sat_cnt_q, sat_cnt_d;

   assign sat_any = (saturate(re_sh, DATA_W) != re_sh) || (saturate(im_sh, DATA_W) != im_sh);

   // A clear in the same cycle as a saturated result wins.
   always_comb begin
      sat_cnt_d = sat_cnt_q;
      if (phase_clr_i)
         sat_cnt_d = '0;
      else if (vld_pipe_q[LATENCY-1] && sat_any && sat_cnt_q != 16'hFFFF)
         sat_cnt_d = sat_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sat_cnt_q <= '0;
      else      sat_cnt_q <= sat_cnt_d;
   end

   assign sat_cnt_o = sat_cnt_q;
`endif

endmodule
